hub75_capture: RTL and testbench
================================

# hub75_capture

Receiving end of the LED-matrix panel interface: consumes the `sclk`/`lat`/`blank`/`disp_row`/`rgb1`/`rgb2` stream that the sequencer and pixel generator drive, and reconstructs what the panel would display. Each latched row is emitted as a column-ordered pixel-write stream with a valid/ready handshake, suitable for a frame-buffer writer or a scoreboard. It also flags protocol errors. It is used as a panel model in system simulation and on-board loopback.

## Interface
- `COLS`, 32: shift-chain length, in pixels per row.
- `ROWS`, 8: number of `disp_row` values per frame. `ROWS` ≤ 8.
- `clk` in 1: system clock, the same clock that generates the panel signals.
- `rst` in 1: synchronous, active-low reset.
- `sclk` in 1: panel shift clock.
- `blank` in 1: panel blank.
- `lat` in 1: panel latch.
- `disp_row` in 3: row address.
- `rgb1` in 3: upper-half pixel, {r,g,b}.
- `rgb2` in 3: lower-half pixel, {r,g,b}.
- `wr_valid` out 1: pixel write is valid.
- `wr_ready` in 1: downstream accepts the write.
- `wr_row` out 3: row of the current write.
- `wr_col` out 8: column of the current write, 0..COLS-1.
- `wr_rgb1` out 3, `wr_rgb2` out 3: pixel data for the current write.
- `frame_done` out 1: one-cycle pulse when the last write of row ROWS-1 is accepted.
- `len_err` out 1: sticky flag; a latch occurred with a shift count ≠ COLS.
- `lat_err` out 1: sticky flag; a latch occurred while `blank` was low.
- `ovr_err` out 1: sticky flag; a latch occurred while a row was still draining.

## Operation
- **Input stage:** all panel inputs are registered once, giving value s(t). A second register holds s(t-1). A rising edge is detected when s(t-1)=0 and s(t)=1.
- **Shift register:** COLS entries of 6 bits each.
  - On each `sclk` rise, {rgb1,rgb2} from s(t) enter entry 0 and every entry moves up by one.
  - After exactly COLS shifts, the first pixel shifted in sits at column COLS-1.
  - `shift_cnt` counts shifts since the last latch and saturates at COLS+1.
  - Shifting never stalls, including during a drain.
- **Latch:** on a `lat` rise:
  - If the FSM is in IDLE: copy the shift register into the row buffer, capture `disp_row` from s(t) into `wr_row`, and enter DRAIN.
  - If the FSM is in DRAIN: set `ovr_err`, leave the row buffer unchanged, and discard the new latch.
  - In both cases: if `shift_cnt` ≠ COLS, set `len_err`; if `blank` in s(t)=0, set `lat_err`; then clear `shift_cnt`.
- **Same-sample `sclk` and `lat` rise:** the shift is applied first, and the latched data includes the new pixel.
- **FSM:**
  - IDLE: `wr_valid`=0.
  - DRAIN: `wr_valid`=1. `wr_col` starts at 0, and data = row buffer[`wr_col`].
  - On `wr_valid`&&`wr_ready`: if `wr_col`=COLS-1, go to IDLE and set `wr_col`=0; otherwise increment `wr_col`.
- **Handshake rules:**
  - Outputs stay stable while `wr_valid`=1 and `wr_ready`=0.
  - `wr_valid` never drops without a handshake.
- **`frame_done`:** pulses in the same cycle as the accepted beat with `wr_row`=ROWS-1 and `wr_col`=COLS-1.
- **Error flags:** stay set until reset.

## Timing
- **Reset** (`rst`=0 at a clock edge), all synchronous:
  - State registers: FSM=IDLE, `shift_cnt`=0, edge registers=0.
  - Outputs: `wr_valid`=0, `wr_row`=0, `wr_col`=0, `wr_rgb1`=0, `wr_rgb2`=0, `frame_done`=0, all error flags=0.
  - Shift-register and row-buffer contents are don't-care.
  - Reset during DRAIN abandons the row.
- **Shift latency:** an input change at edge t appears in s at t+1. An edge is detected in the cycle after t+1, and the shift occurs at edge t+2.
- **Latch latency:** a `lat` rise sampled at edge t+1 loads the row buffer at edge t+2. `wr_valid`=1 from the cycle after t+2.
- **Drain duration:** with `wr_ready` held high, a row drains in exactly COLS cycles.
- **Back-to-back drains:** `lat` for the next row may be accepted in the cycle that follows the final beat.
- **Width rules:**
  - `wr_col` is 8 bits; COLS ≤ 256.
  - `shift_cnt` is ⌈log2(COLS+2)⌉ bits, which is sufficient for saturation at COLS+1.

## Test plan
1. Shift 32 pixels with pixel k={k[2:0],~k[2:0]}, with `blank`=1, then `lat`, `disp_row`=3, `wr_ready`=1 → 32 beats: `wr_row`=3; at `wr_col`=c, rgb1=(31-c)[2:0] and rgb2=~(31-c)[2:0]; no error flags set.
2. Same as test 1 with `wr_ready` toggled 1/0 every cycle → identical beat sequence; outputs held while stalled; drain takes 63 cycles.
3. Full frame of rows 0..7, each with 32 shifts and a latch → exactly one `frame_done` pulse, on row 7 column 31.
4. Latch after 31 shifts, and separately a latch with `blank`=0 → `len_err`=1 and `lat_err`=1 respectively; rows still drain normally.
5. Second `lat` while `wr_ready`=0 holds the drain → `ovr_err`=1; the drained data equals the first row.
6. Assert `rst`=0 for one cycle mid-drain → next cycle `wr_valid`=0 and all flags=0; a subsequent row captures correctly.

Source files
------------

// File: rtl/hub75_capture.sv
// HUB75 panel receiver: rebuilds each latched row from the sclk/lat stream and
// replays it as a column-ordered valid/ready pixel-write stream with error flags.
module hub75_capture #(
   parameter int COLS = 32,
   parameter int ROWS = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sclk,
   input  logic       blank,
   input  logic       lat,
   input  logic [2:0] disp_row,
   input  logic [2:0] rgb1,
   input  logic [2:0] rgb2,
   output logic       wr_valid,
   input  logic       wr_ready,
   output logic [2:0] wr_row,
   output logic [7:0] wr_col,
   output logic [2:0] wr_rgb1,
   output logic [2:0] wr_rgb2,
   output logic       frame_done,
   output logic       len_err,
   output logic       lat_err,
   output logic       ovr_err
);

   localparam int              CNTW     = $clog2(COLS + 2);
   localparam logic [CNTW-1:0] CNT_FULL = CNTW'(COLS);
   localparam logic [CNTW-1:0] CNT_SAT  = CNTW'(COLS + 1);
   localparam logic [7:0]      LAST_COL = 8'(COLS - 1);
   localparam logic [2:0]      LAST_ROW = 3'(ROWS - 1);

   typedef enum logic {IDLE, DRAIN} state_t;

   state_t          r_state, w_state_nxt;
   logic            r_sclk_p0, r_lat_p0, r_blank_p0;
   logic [2:0]      r_row_p0, r_rgb1_p0, r_rgb2_p0;
   logic            r_sclk_p1, r_lat_p1;
   logic [CNTW-1:0] r_shift_cnt, w_cnt_nxt;
   logic [5:0]      r_sr     [COLS];
   logic [5:0]      w_sr_nxt [COLS];
   logic [5:0]      r_rowbuf [COLS];
   logic [5:0]      w_pix;
   logic [7:0]      r_wr_col;
   logic [2:0]      r_wr_row;
   logic            r_len_err, r_lat_err, r_ovr_err;
   logic            w_sclk_rise, w_lat_rise, w_beat, w_last;

   function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
      return (v == CNT_SAT) ? v : v + 1'b1;
   endfunction

   // Stage p0: registered panel inputs; stage p1: previous sample for edge detect
   always_ff @(posedge clk) begin
      r_rgb1_p0  <= rgb1;
      r_rgb2_p0  <= rgb2;
      r_row_p0   <= disp_row;
      r_blank_p0 <= blank;
      if (!rst) begin
         r_sclk_p0 <= 1'b0;
         r_lat_p0  <= 1'b0;
         r_sclk_p1 <= 1'b0;
         r_lat_p1  <= 1'b0;
      end else begin
         r_sclk_p0 <= sclk;
         r_lat_p0  <= lat;
         r_sclk_p1 <= r_sclk_p0;
         r_lat_p1  <= r_lat_p0;
      end
   end

   assign w_sclk_rise = r_sclk_p0 & ~r_sclk_p1;
   assign w_lat_rise  = r_lat_p0 & ~r_lat_p1;

   // Shift is resolved before the latch so a coincident rise lands in the row
   always_comb begin
      w_sr_nxt = r_sr;
      if (w_sclk_rise) begin
         w_sr_nxt[0] = {r_rgb1_p0, r_rgb2_p0};
         for (int i = 1; i < COLS; i++) w_sr_nxt[i] = r_sr[i-1];
      end
      w_cnt_nxt = w_sclk_rise ? sat_inc(r_shift_cnt) : r_shift_cnt;
   end

   always_ff @(posedge clk) begin
      r_sr <= w_sr_nxt;
      if (w_lat_rise && r_state == IDLE) r_rowbuf <= w_sr_nxt;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_shift_cnt <= '0;
         r_wr_row    <= '0;
         r_wr_col    <= '0;
         r_len_err   <= 1'b0;
         r_lat_err   <= 1'b0;
         r_ovr_err   <= 1'b0;
      end else begin
         r_shift_cnt <= w_lat_rise ? '0 : w_cnt_nxt;
         if (w_lat_rise) begin
            if (w_cnt_nxt != CNT_FULL) r_len_err <= 1'b1;
            if (!r_blank_p0)           r_lat_err <= 1'b1;
            if (r_state == DRAIN)      r_ovr_err <= 1'b1;
            else                       r_wr_row  <= r_row_p0;
         end
         if (w_beat) r_wr_col <= w_last ? 8'd0 : r_wr_col + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) r_state <= IDLE;
      else      r_state <= w_state_nxt;
   end

   assign w_last = (r_wr_col == LAST_COL);
   assign w_beat = wr_valid & wr_ready;

   always_comb begin
      w_state_nxt = r_state;
      wr_valid    = 1'b0;
      frame_done  = 1'b0;
      case (r_state)
         IDLE: if (w_lat_rise) w_state_nxt = DRAIN;
         DRAIN: begin
            wr_valid = 1'b1;
            if (wr_ready && w_last) begin
               w_state_nxt = IDLE;
               frame_done  = (r_wr_row == LAST_ROW);
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Column select without truncating wr_col, so any COLS up to 256 works
   always_comb begin
      w_pix = '0;
      for (int i = 0; i < COLS; i++)
         if (r_wr_col == 8'(i)) w_pix = r_rowbuf[i];
   end

   assign wr_row  = r_wr_row;
   assign wr_col  = r_wr_col;
   assign wr_rgb1 = (r_state == DRAIN) ? w_pix[5:3] : 3'd0;
   assign wr_rgb2 = (r_state == DRAIN) ? w_pix[2:0] : 3'd0;
   assign len_err = r_len_err;
   assign lat_err = r_lat_err;
   assign ovr_err = r_ovr_err;

endmodule

// File: tb/tb_hub75_capture.sv
// Scoreboard bench for hub75_capture: a panel model pushes expected beats on
// every accepted latch; the write-side monitor pops and compares them.
module tb_hub75_capture;

   logic       clk, rst, sclk, blank, lat, wr_ready;
   logic [2:0] disp_row, rgb1, rgb2;
   logic       wr_valid, frame_done, len_err, lat_err, ovr_err;
   logic [2:0] wr_row, wr_rgb1, wr_rgb2;
   logic [7:0] wr_col;

   typedef struct {
      logic [2:0] row;
      logic [7:0] col;
      logic [2:0] r1;
      logic [2:0] r2;
   } beat_t;

   beat_t      sbq[$];
   beat_t      e;
   logic [5:0] m_sr [32];
   int         n_checks, n_errors;
   int         rmode, fd_cnt, vcnt, last_drain;
   logic       pv, hold_pend;
   logic [16:0] hold_val;

   hub75_capture #(.COLS(32), .ROWS(8)) dut (
      .clk(clk), .rst(rst), .sclk(sclk), .blank(blank), .lat(lat),
      .disp_row(disp_row), .rgb1(rgb1), .rgb2(rgb2),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_row(wr_row), .wr_col(wr_col),
      .wr_rgb1(wr_rgb1), .wr_rgb2(wr_rgb2), .frame_done(frame_done),
      .len_err(len_err), .lat_err(lat_err), .ovr_err(ovr_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   // Ready pattern: 0 = always high, 1 = toggle starting high on first valid cycle, 2 = held low
   initial begin
      wr_ready = 1'b1;
      pv = 1'b0;
      forever begin
         @(posedge clk); #1;
         case (rmode)
            0:       wr_ready = 1'b1;
            1:       wr_ready = pv ? ~wr_ready : 1'b1;
            default: wr_ready = 1'b0;
         endcase
         pv = wr_valid;
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         hold_pend = 1'b0;
      end else begin
         if (hold_pend) begin
            chk("hold_valid", {31'd0, wr_valid}, 32'd1);
            chk("hold_data", {15'd0, wr_row, wr_col, wr_rgb1, wr_rgb2}, {15'd0, hold_val});
         end
         if (wr_valid) vcnt++;
         if (frame_done) fd_cnt++;
         if (wr_valid && wr_ready) begin
            if (sbq.size() == 0) begin
               chk("extra_beat", 32'd1, 32'd0);
            end else begin
               e = sbq.pop_front();
               chk("beat", {15'd0, wr_row, wr_col, wr_rgb1, wr_rgb2},
                   {15'd0, e.row, e.col, e.r1, e.r2});
               chk("frame_done", {31'd0, frame_done},
                   {31'd0, (e.row == 3'd7 && e.col == 8'd31)});
            end
            if (wr_col == 8'd31) begin
               last_drain = vcnt;
               vcnt = 0;
            end
         end
         hold_pend = wr_valid && !wr_ready;
         hold_val  = {wr_row, wr_col, wr_rgb1, wr_rgb2};
      end
   end

   task automatic shift_px(input logic [2:0] a, input logic [2:0] b);
      @(posedge clk); #1;
      sclk = 1'b0; rgb1 = a; rgb2 = b;
      @(posedge clk); #1;
      sclk = 1'b1;
      for (int i = 31; i > 0; i--) m_sr[i] = m_sr[i-1];
      m_sr[0] = {a, b};
   endtask

   task automatic shift_rand(input int n);
      for (int k = 0; k < n; k++) shift_px(3'($urandom), 3'($urandom));
   endtask

   task automatic push_model(input logic [2:0] row);
      beat_t b;
      for (int c = 0; c < 32; c++) begin
         b.row = row; b.col = 8'(c); b.r1 = m_sr[c][5:3]; b.r2 = m_sr[c][2:0];
         sbq.push_back(b);
      end
   endtask

   task automatic latch(input logic [2:0] row, input logic b);
      @(posedge clk); #1;
      sclk = 1'b0; lat = 1'b0; disp_row = row; blank = b;
      @(posedge clk); #1;
      lat = 1'b1;
      @(posedge clk); #1;
      lat = 1'b0; blank = 1'b1;
   endtask

   task automatic wait_valid(input int n);
      int i = 0;
      while (!wr_valid && i < n) begin @(negedge clk); i++; end
      chk("wait_valid_to", {31'd0, wr_valid}, 32'd1);
   endtask

   task automatic wait_idle(input int n);
      int i = 0;
      while ((sbq.size() != 0 || wr_valid) && i < n) begin @(negedge clk); i++; end
      chk("drain_to", {31'd0, (sbq.size() == 0 && !wr_valid)}, 32'd1);
   endtask

   task automatic chk_flags(input string tag, input logic le, input logic la, input logic ov);
      chk(tag, {29'd0, len_err, lat_err, ovr_err}, {29'd0, le, la, ov});
   endtask

   task automatic do_reset;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      sbq.delete();
      vcnt = 0;
   endtask

   task automatic chk_reset_state;
      @(negedge clk);
      chk("rst_valid", {31'd0, wr_valid}, 32'd0);
      chk("rst_outs", {16'd0, wr_row, wr_col, wr_rgb1, wr_rgb2}, 32'd0);
      chk("rst_fd", {31'd0, frame_done}, 32'd0);
      chk_flags("rst_flags", 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      beat_t b;
      n_checks = 0; n_errors = 0; rmode = 0; fd_cnt = 0; vcnt = 0; last_drain = 0;
      hold_pend = 1'b0; hold_val = '0;
      rst = 1'b0; sclk = 1'b0; lat = 1'b0; blank = 1'b1;
      disp_row = 3'd0; rgb1 = 3'd0; rgb2 = 3'd0;
      for (int i = 0; i < 32; i++) m_sr[i] = 6'd0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      chk_reset_state();

      // Test 1: ramp pattern, formula-based expectation
      for (int k = 0; k < 32; k++) shift_px(3'(k), ~3'(k));
      for (int c = 0; c < 32; c++) begin
         b.row = 3'd3; b.col = 8'(c); b.r1 = 3'(31 - c); b.r2 = ~3'(31 - c);
         sbq.push_back(b);
      end
      latch(3'd3, 1'b1);
      wait_idle(200);
      chk("t1_drain_len", last_drain, 32'd32);
      chk_flags("t1_flags", 1'b0, 1'b0, 1'b0);

      // Test 2: same row, ready toggling
      rmode = 1;
      for (int k = 0; k < 32; k++) shift_px(3'(k), ~3'(k));
      push_model(3'd3);
      latch(3'd3, 1'b1);
      wait_idle(400);
      chk("t2_drain_len", last_drain, 32'd63);
      rmode = 0;

      // Test 3: full frame
      fd_cnt = 0;
      for (int r = 0; r < 8; r++) begin
         shift_rand(32);
         push_model(3'(r));
         latch(3'(r), 1'b1);
         wait_idle(200);
      end
      chk("t3_fd_count", fd_cnt, 32'd1);
      chk_flags("t3_flags", 1'b0, 1'b0, 1'b0);

      // Test 4: short row, then latch while unblanked
      do_reset();
      shift_rand(31);
      push_model(3'd1);
      latch(3'd1, 1'b1);
      wait_idle(200);
      chk_flags("t4_len", 1'b1, 1'b0, 1'b0);
      do_reset();
      shift_rand(32);
      push_model(3'd4);
      latch(3'd4, 1'b0);
      wait_idle(200);
      chk_flags("t4_lat", 1'b0, 1'b1, 1'b0);

      // Test 5: second latch during a stalled drain is dropped
      do_reset();
      rmode = 2;
      shift_rand(32);
      push_model(3'd2);
      latch(3'd2, 1'b1);
      wait_valid(20);
      shift_rand(32);
      latch(3'd5, 1'b1);
      repeat (3) @(negedge clk);
      chk_flags("t5_ovr", 1'b0, 1'b0, 1'b1);
      rmode = 0;
      wait_idle(200);
      chk("t5_row", {29'd0, wr_row}, 32'd2);

      // Test 6: reset mid-drain
      do_reset();
      rmode = 2;
      shift_rand(32);
      push_model(3'd6);
      latch(3'd6, 1'b0);
      wait_valid(20);
      repeat (3) @(negedge clk);
      chk_flags("t6_pre", 1'b0, 1'b1, 1'b0);
      do_reset();
      chk_reset_state();
      rmode = 0;
      shift_rand(32);
      push_model(3'd1);
      latch(3'd1, 1'b1);
      wait_idle(200);
      chk_flags("t6_post", 1'b0, 1'b0, 1'b0);
      chk("sb_empty", sbq.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
